// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-stage Tnew scoreboard driving PC/ID stall and ID/EX clear, plus multdiv busy and stall counters
module hazard_scoreboard #(
    parameter int NUM_STAGES  = 4,
    parameter int T_WIDTH     = 3,
    parameter int REG_AW      = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [T_WIDTH-1:0] id_tuse_rs,
    input  logic [T_WIDTH-1:0] id_tuse_rt,
    input  logic [REG_AW-1:0]  id_dst,
    input  logic [T_WIDTH-1:0] id_tnew,
    input  logic               id_is_md,
    input  logic               md_start,
    input  logic               md_is_div,
    input  logic               flush,
    output logic               stall_pc,
    output logic               stall_id,
    output logic               clr_ex,
    output logic               md_busy,
    output logic [31:0]        stall_count
);
    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [REG_AW-1:0]     a_q [NUM_STAGES];
    logic [REG_AW-1:0]     a_d [NUM_STAGES];
    logic [T_WIDTH-1:0]    t_q [NUM_STAGES];
    logic [T_WIDTH-1:0]    t_d [NUM_STAGES];
    logic [CNT_W-1:0]      md_cnt_q, md_cnt_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;
    logic                  hit_rs, hit_rt, md_launch, md_nz, stall_md, stall;

    assign md_launch = md_start & ~flush;
    assign md_nz     = md_cnt_q != '0;
    assign stall_md  = id_valid & id_is_md & (md_nz | md_launch);

    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (v_q[k] && a_q[k] == id_rs && t_q[k] > id_tuse_rs) hit_rs = 1'b1;
            if (v_q[k] && a_q[k] == id_rt && t_q[k] > id_tuse_rt) hit_rt = 1'b1;
        end
    end

    assign stall       = (id_valid & (id_rs != '0) & hit_rs) | (id_valid & (id_rt != '0) & hit_rt) | stall_md;
    // outputs are held low while reset is asserted, even if ID/EX inputs are active
    assign stall_pc    = reset_n & stall & ~flush;
    assign stall_id    = stall_pc;
    assign clr_ex      = reset_n & (stall | flush);
    assign md_busy     = reset_n & md_nz;
    assign stall_count = stall_cnt_q;

    // shift runs every cycle; a stalled ID injects a bubble into entry 0
    always_comb begin
        v_d[0] = id_valid & (id_dst != '0) & (id_tnew > T_WIDTH'(1)) & ~stall & ~flush;
        a_d[0] = id_dst;
        t_d[0] = id_tnew - T_WIDTH'(1);
        for (int k = 1; k < NUM_STAGES; k++) begin
            v_d[k] = ~flush & v_q[k-1] & (t_q[k-1] > T_WIDTH'(1));
            a_d[k] = a_q[k-1];
            t_d[k] = (t_q[k-1] == '0) ? '0 : t_q[k-1] - T_WIDTH'(1);
        end
        md_cnt_d    = md_launch ? (md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES))
                                : md_cnt_q - (md_nz ? CNT_W'(1) : CNT_W'(0));
        stall_cnt_d = (stall_pc && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q         <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            a_q[k] <= a_d[k];
            t_q[k] <= t_d[k];
        end
    end
endmodule
